// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_keyboard_rx_pkg
//   Shared definitions for the PS/2 keyboard receiver: frame FSM state
//   encoding, fixed start/stop bit levels, the default inter-edge timeout
//   and the odd-parity check used on frame completion.
package ps2_keyboard_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic PS2_START_BIT = 1'b0;
   localparam logic PS2_STOP_BIT  = 1'b1;

   // 1 ms at 50 MHz: far longer than any legal PS/2 bit period (60-100 us).
   localparam int PS2_TIMEOUT_CYCLES = 50_000;

   // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
   function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/scancode_fifo.sv
// scancode_fifo
//   Synchronous show-ahead FIFO. The head entry is presented combinationally
//   on head (0 when empty). A push into a full FIFO is accepted only when a
//   pop happens in the same cycle, so a full FIFO can stream without loss.
// Ports:
//   clk, reset     clock, asynchronous active-low reset (pointers/count only)
//   push,push_data write request and data
//   pop            read request; ignored when empty
//   head           current head entry, 0 when empty
//   valid          FIFO non-empty
//   count          current occupancy, 0..DEPTH
//   full           occupancy equals DEPTH
module scancode_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        head,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count_q;
   logic              do_push;
   logic              do_pop;

   assign valid  = (count_q != '0);
   assign full   = (count_q == FULL_CNT);
   assign count  = count_q;
   assign head   = valid ? mem[rd_ptr] : '0;

   assign do_pop  = pop & valid;
   // When full, the slot being pushed is the one freed by the simultaneous pop.
   assign do_push = push & (~full | do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   PS/2 keyboard receiver. Synchronizes the raw PS/2 pins, samples data on
//   falling edges of the device clock, checks start/parity/stop, and pushes
//   good scancodes into a show-ahead FIFO polled by the CPU.
// Ports:
//   clk, reset      50 MHz system clock, asynchronous active-low reset
//   ps2_clk/data    raw asynchronous PS/2 connector pins
//   rd_en           pop the head entry (ignored when empty)
//   clear_err       clear the sticky error flags (a same-cycle set wins)
//   scancode        FIFO head, 0 when empty
//   valid, count    FIFO non-empty, current occupancy
//   parity_err      sticky: frame dropped for bad parity
//   frame_err       sticky: frame dropped for bad start/stop or timeout
//   overflow        sticky: good frame dropped because the FIFO was full
module ps2_keyboard_rx
   import ps2_keyboard_rx_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rd_en,
   input  logic                          clear_err,
   output logic [7:0]                    scancode,
   output logic                          valid,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

   logic             ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
   logic             ps2_data_p0, ps2_data_p1;
   logic             fall_edge;

   ps2_state_e       state, state_nxt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             parity_bit;
   logic [GAP_W-1:0] gap_cnt;

   logic             shift_en, parity_ld, good_frame, set_parity, set_frame;
   logic             vld_p3;
   logic [7:0]       scancode_p3;
   logic             fifo_full;
   logic             set_overflow;

   // ---- stage p0/p1: two-flop synchronizers; p2: previous clock level ----
   // Reset to 1 so an idle-high bus does not look like an edge after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps2_clk_p0  <= 1'b1;
         ps2_clk_p1  <= 1'b1;
         ps2_clk_p2  <= 1'b1;
         ps2_data_p0 <= 1'b1;
         ps2_data_p1 <= 1'b1;
      end else begin
         ps2_clk_p0  <= ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_clk_p2  <= ps2_clk_p1;
         ps2_data_p0 <= ps2_data;
         ps2_data_p1 <= ps2_data_p0;
      end
   end

   assign fall_edge = ps2_clk_p2 & ~ps2_clk_p1;

   // ---- frame FSM: next state and per-edge actions ----
   always_comb begin
      state_nxt  = state;
      shift_en   = 1'b0;
      parity_ld  = 1'b0;
      good_frame = 1'b0;
      set_parity = 1'b0;
      set_frame  = 1'b0;
      if (fall_edge) begin
         case (state)
            IDLE: begin
               // A high bit in IDLE is line noise, not a frame: ignore it silently.
               if (ps2_data_p1 == PS2_START_BIT) state_nxt = DATA;
            end
            DATA: begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: begin
               parity_ld = 1'b1;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (ps2_data_p1 != PS2_STOP_BIT)
                  set_frame = 1'b1;
               else if (!ps2_parity_ok(shift_reg, parity_bit))
                  set_parity = 1'b1;
               else
                  good_frame = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (state != IDLE && gap_cnt == GAP_LIMIT) begin
         state_nxt = IDLE;
         set_frame = 1'b1;
      end
   end

   assign set_overflow = vld_p3 & fifo_full & ~rd_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         vld_p3     <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE)
            bit_cnt <= '0;
         else if (shift_en)
            bit_cnt <= bit_cnt + 3'd1;
         // The gap counter only measures time inside a frame.
         if (fall_edge || state == IDLE)
            gap_cnt <= '0;
         else
            gap_cnt <= gap_cnt + GAP_W'(1);
         vld_p3     <= good_frame;
         parity_err <= set_parity   | (parity_err & ~clear_err);
         frame_err  <= set_frame    | (frame_err  & ~clear_err);
         overflow   <= set_overflow | (overflow   & ~clear_err);
      end
   end

   // Data path registers carry no reset; they are only consumed after being loaded.
   always_ff @(posedge clk) begin
      if (shift_en)   shift_reg   <= {ps2_data_p1, shift_reg[7:1]};
      if (parity_ld)  parity_bit  <= ps2_data_p1;
      if (good_frame) scancode_p3 <= shift_reg;
   end

   // ---- stage p3: registered push into the scancode FIFO ----
   scancode_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (vld_p3),
      .push_data (scancode_p3),
      .pop       (rd_en),
      .head      (scancode),
      .valid     (valid),
      .count     (count),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

   localparam int DEPTH = 8;
   localparam int TMO   = 100;
   localparam int HALF  = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       clear_err = 1'b0;
   logic [7:0] scancode;
   logic       valid;
   logic [3:0] count;
   logic       parity_err, frame_err, overflow;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rd_en      (rd_en),
      .clear_err  (clear_err),
      .scancode   (scancode),
      .valid      (valid),
      .count      (count),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overflow   (overflow)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      idle(HALF/2);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
      idle(HALF/2);
   endtask

   // rd_at_stop raises rd_en in the FIFO push cycle of this frame:
   // 3 cycles to detect the stop-bit edge, one more for the registered push.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                             input logic rd_at_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      ps2_data = stp;
      idle(HALF/2);
      ps2_clk = 1'b0;
      if (rd_at_stop) begin
         idle(3);
         rd_en = 1'b1;
         idle(1);
         rd_en = 1'b0;
         idle(HALF-4);
      end else begin
         idle(HALF);
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      idle(HALF/2 + 4);
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic pulse_clear();
      clear_err = 1'b1;
      idle(1);
      clear_err = 1'b0;
      idle(1);
   endtask

   task automatic pop_check(input string name);
      logic [7:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      n_vec++;
      if (valid !== 1'b1 || scancode !== e) begin
         n_err++;
         $display("FAIL %s: valid=%b scancode=%h, required valid=1 scancode=%h", name, valid, scancode, e);
      end
      rd_en = 1'b1;
      idle(1);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      idle(3);
      n_vec++;
      if ({valid, count, scancode, parity_err, frame_err, overflow} !== '0) begin
         n_err++;
         $display("FAIL reset_state: valid=%b count=%0d scancode=%h pe=%b fe=%b ov=%b, required all 0",
                  valid, count, scancode, parity_err, frame_err, overflow);
      end
      reset = 1'b1;
      idle(3);
   endtask

   task automatic test_single();
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(8'h1C);
      n_vec++;
      if (valid !== 1'b1 || count !== 4'd1) begin
         n_err++;
         $display("FAIL single_push: valid=%b count=%0d, required valid=1 count=1", valid, count);
      end
      pop_check("single_head");
      n_vec++;
      if (valid !== 1'b0 || count !== 4'd0 || scancode !== 8'h00) begin
         n_err++;
         $display("FAIL single_pop: valid=%b count=%0d scancode=%h, required 0 0 00", valid, count, scancode);
      end
   endtask

   task automatic test_parity();
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (count !== 4'd0 || parity_err !== 1'b1 || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL parity_drop: count=%0d pe=%b fe=%b, required count=0 pe=1 fe=0", count, parity_err, frame_err);
      end
      pulse_clear();
      n_vec++;
      if (parity_err !== 1'b0) begin
         n_err++;
         $display("FAIL parity_clear: pe=%b, required 0", parity_err);
      end
   endtask

   task automatic test_frame_err();
      send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (count !== 4'd0 || frame_err !== 1'b1 || parity_err !== 1'b0) begin
         n_err++;
         $display("FAIL stop_bit: count=%0d fe=%b pe=%b, required count=0 fe=1 pe=0", count, frame_err, parity_err);
      end
      pulse_clear();
   endtask

   task automatic test_overflow();
      logic exp_ovf;
      exp_ovf = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         send_frame(8'(i), odd_par(8'(i)), 1'b1, 1'b0);
         if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
         else exp_ovf = 1'b1;
      end
      n_vec++;
      if (count !== 4'(exp_q.size()) || overflow !== exp_ovf || scancode !== exp_q[0]) begin
         n_err++;
         $display("FAIL overflow: count=%0d ov=%b head=%h, required count=%0d ov=%b head=%h",
                  count, overflow, scancode, exp_q.size(), exp_ovf, exp_q[0]);
      end
      for (int i = 0; i < DEPTH; i++) pop_check("overflow_drain");
      // Popping an empty FIFO must leave it empty.
      rd_en = 1'b1;
      idle(1);
      rd_en = 1'b0;
      n_vec++;
      if (count !== 4'd0 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL empty_pop: count=%0d valid=%b, required 0 0", count, valid);
      end
      pulse_clear();
      n_vec++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_clear: ov=%b, required 0", overflow);
      end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'h10 + 8'(i), odd_par(8'h10 + 8'(i)), 1'b1, 1'b0);
         exp_q.push_back(8'h10 + 8'(i));
      end
      n_vec++;
      if (scancode !== exp_q[0] || count !== 4'(DEPTH)) begin
         n_err++;
         $display("FAIL full_head: head=%h count=%0d, required %h %0d", scancode, count, exp_q[0], DEPTH);
      end
      void'(exp_q.pop_front());
      send_frame(8'h2A, odd_par(8'h2A), 1'b1, 1'b1);
      exp_q.push_back(8'h2A);
      n_vec++;
      if (count !== 4'(DEPTH) || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL full_rw: count=%0d ov=%b, required count=%0d ov=0", count, overflow, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) pop_check("full_rw_drain");
   endtask

   task automatic test_timeout();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      idle(TMO + 10);
      n_vec++;
      if (frame_err !== 1'b1 || count !== 4'd0) begin
         n_err++;
         $display("FAIL timeout: fe=%b count=%0d, required fe=1 count=0", frame_err, count);
      end
      pulse_clear();
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
      exp_q.push_back(8'hF0);
      n_vec++;
      if (count !== 4'd1 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
         n_err++;
         $display("FAIL after_timeout: count=%0d fe=%b pe=%b, required 1 0 0", count, frame_err, parity_err);
      end
      pop_check("after_timeout_head");
   endtask

   task automatic test_reset_mid();
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      reset = 1'b0;
      idle(3);
      reset = 1'b1;
      idle(3);
      for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), odd_par(8'h40 + 8'(i)), 1'b1, 1'b0);
      n_vec++;
      if (count !== 4'd3) begin
         n_err++;
         $display("FAIL reset_fill: count=%0d, required 3", count);
      end
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if ({valid, count, scancode, parity_err, frame_err, overflow} !== '0) begin
         n_err++;
         $display("FAIL async_reset: valid=%b count=%0d scancode=%h, required all 0", valid, count, scancode);
      end
      idle(3);
      reset = 1'b1;
      idle(3);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(8'h1C);
      n_vec++;
      if (count !== 4'd1) begin
         n_err++;
         $display("FAIL post_reset: count=%0d, required 1", count);
      end
      pop_check("post_reset_head");
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_frame_err();
      test_overflow();
      test_full_rw();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
